// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (F) and data load/store (D).
// Data wins ties unless fetch has been starved; a watchdog aborts accesses that are never acked.
module mem_port_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic       OWN_F   = 1'b0;
    localparam logic       OWN_D   = 1'b1;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TO_LIM     = 8'(TIMEOUT);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [7:0]        to_cnt_q, to_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              f_gnt_q, f_gnt_d, d_gnt_q, d_gnt_d;
    logic              f_done_q, f_done_d, d_done_q, d_done_d;
    logic [DATA_W-1:0] f_rdata_q, f_rdata_d, d_rdata_q, d_rdata_d;
    logic              f_err_q, f_err_d, d_err_q, d_err_d;
    logic              busy_q, busy_d;
    logic              grant_d_s, grant_f_s, finish_s, err_s;
    logic [DATA_W-1:0] rdata_s;

    // Next-state logic: arbitration, access sequencing and watchdog.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        to_cnt_d     = to_cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        f_gnt_d      = 1'b0;
        d_gnt_d      = 1'b0;
        f_done_d     = 1'b0;
        d_done_d     = 1'b0;
        f_rdata_d    = '0;
        d_rdata_d    = '0;
        f_err_d      = 1'b0;
        d_err_d      = 1'b0;
        grant_d_s    = 1'b0;
        grant_f_s    = 1'b0;
        finish_s     = 1'b0;
        err_s        = 1'b0;
        rdata_s      = '0;

        case (state_q)
            ST_IDLE: begin
                // Fetch only overtakes data once it has lost STARVE_MAX grants in a row.
                if (d_req && !(f_req && (starve_cnt_q == STARVE_LIM))) begin
                    grant_d_s = 1'b1;
                end else if (f_req) begin
                    grant_f_s = 1'b1;
                end else begin
                    grant_d_s = 1'b0;
                end

                if (grant_d_s) begin
                    owner_d     = OWN_D;
                    mem_addr_d  = d_addr;
                    mem_we_d    = d_we;
                    mem_wdata_d = d_wdata;
                    d_gnt_d     = 1'b1;
                    if (f_req) begin
                        if (starve_cnt_q < STARVE_LIM) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end else begin
                            starve_cnt_d = starve_cnt_q;
                        end
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (grant_f_s) begin
                    owner_d      = OWN_F;
                    mem_addr_d   = f_addr;
                    mem_we_d     = 1'b0;
                    mem_wdata_d  = '0;
                    f_gnt_d      = 1'b1;
                    starve_cnt_d = 4'd0;
                end else begin
                    state_d = ST_IDLE;
                end

                if (grant_d_s || grant_f_s) begin
                    mem_req_d = 1'b1;
                    to_cnt_d  = 8'd0;
                    state_d   = ST_BUSY;
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            ST_BUSY: begin
                // An ack on the timeout cycle still counts as a normal completion.
                if (mem_ack) begin
                    finish_s = 1'b1;
                    rdata_s  = mem_we_q ? '0 : mem_rdata;
                end else if ((to_cnt_q + 8'd1) == TO_LIM) begin
                    finish_s = 1'b1;
                    err_s    = 1'b1;
                    to_cnt_d = to_cnt_q + 8'd1;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase

        if (finish_s) begin
            state_d   = ST_RESP;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            if (owner_q == OWN_D) begin
                d_done_d  = 1'b1;
                d_rdata_d = rdata_s;
                d_err_d   = err_s;
            end else begin
                f_done_d  = 1'b1;
                f_rdata_d = rdata_s;
                f_err_d   = err_s;
            end
        end else begin
            finish_s = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any access without a completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_F;
            starve_cnt_q <= 4'd0;
            to_cnt_q     <= 8'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            f_gnt_q      <= 1'b0;
            d_gnt_q      <= 1'b0;
            f_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            f_rdata_q    <= '0;
            d_rdata_q    <= '0;
            f_err_q      <= 1'b0;
            d_err_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            to_cnt_q     <= to_cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            f_gnt_q      <= f_gnt_d;
            d_gnt_q      <= d_gnt_d;
            f_done_q     <= f_done_d;
            d_done_q     <= d_done_d;
            f_rdata_q    <= f_rdata_d;
            d_rdata_q    <= d_rdata_d;
            f_err_q      <= f_err_d;
            d_err_q      <= d_err_d;
            busy_q       <= busy_d;
        end
    end

    assign f_gnt     = f_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign f_done    = f_done_q;
    assign d_done    = d_done_q;
    assign f_rdata   = f_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign f_err     = f_err_q;
    assign d_err     = d_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected grants and completions are queued
// as stimulus is applied and compared when the arbiter produces them.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              f_req = 1'b0;
    logic [ADDR_W-1:0] f_addr = '0;
    logic              f_gnt, f_done, f_err;
    logic [DATA_W-1:0] f_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt, d_done, d_err;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req, mem_we, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ack = 1'b0;

    typedef struct packed {
        logic              own;   // 1 = data, 0 = fetch
        logic [DATA_W-1:0] rdata;
        logic              err;
    } resp_t;

    resp_t exp_q[$];
    logic  gnt_q[$];
    int    compared = 0;
    int    mismatched = 0;
    int    cyc;

    mem_port_arbiter #(.ADDR_W(13), .DATA_W(8), .STARVE_MAX(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_done(f_done),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_gnt(input string tag);
        int  n = 0;
        logic own;
        while (!(f_gnt || d_gnt) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_gnt_seen"}, 32'(f_gnt | d_gnt), 32'd1);
        if (gnt_q.size() == 0) begin
            check({tag, "_gnt_queue"}, 32'd0, 32'd1);
        end else begin
            own = gnt_q.pop_front();
            check({tag, "_gnt_owner"}, 32'({f_gnt, d_gnt}), own ? 32'd1 : 32'd2);
        end
    endtask

    task automatic wait_done(input string tag);
        int    n = 0;
        resp_t e;
        while (!(f_done || d_done) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() == 0) begin
            check({tag, "_done_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_done_owner"}, 32'({f_done, d_done}), e.own ? 32'd1 : 32'd2);
            check({tag, "_rdata"}, 32'(e.own ? d_rdata : f_rdata), 32'(e.rdata));
            check({tag, "_err"}, 32'(e.own ? d_err : f_err), 32'(e.err));
        end
    endtask

    task automatic do_ack(input int waits, input logic [DATA_W-1:0] data);
        for (int i = 0; i < waits; i++) @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = data;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = '0;
    endtask

    initial begin
        logic own3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pulses", 32'({f_gnt, d_gnt, f_done, d_done}), 32'd0);
        rst = 1'b0;

        // 1: single fetch, ack two cycles after mem_req
        @(negedge clk);
        f_req = 1'b1; f_addr = 13'h0A5;
        gnt_q.push_back(1'b0);
        exp_q.push_back('{own: 1'b0, rdata: 8'h3C, err: 1'b0});
        wait_gnt("t1");
        check("t1_mem_addr", 32'(mem_addr), 32'h0A5);
        check("t1_mem_we", 32'(mem_we), 32'd0);
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        do_ack(2, 8'h3C);
        wait_done("t1");
        f_req = 1'b0;
        @(negedge clk);
        check("t1_busy_low", 32'(busy), 32'd0);
        check("t1_done_once", 32'(f_done), 32'd0);

        // 2: zero-wait data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 13'h1F0; d_wdata = 8'h77;
        gnt_q.push_back(1'b1);
        exp_q.push_back('{own: 1'b1, rdata: 8'h00, err: 1'b0});
        wait_gnt("t2");
        check("t2_mem_we", 32'(mem_we), 32'd1);
        check("t2_mem_wdata", 32'(mem_wdata), 32'h77);
        check("t2_mem_addr", 32'(mem_addr), 32'h1F0);
        do_ack(0, 8'hAA);
        wait_done("t2");
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);

        // 3: both held continuously -> D, D, F, D, D, F
        f_req = 1'b1; f_addr = 13'h010; d_req = 1'b1; d_addr = 13'h020;
        for (int i = 0; i < 6; i++) begin
            own3 = (i % 3 != 2);
            gnt_q.push_back(own3);
            exp_q.push_back('{own: own3, rdata: 8'(8'h40 + i), err: 1'b0});
            wait_gnt($sformatf("t3_%0d", i));
            do_ack(0, 8'(8'h40 + i));
            wait_done($sformatf("t3_%0d", i));
        end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // 4: data read never acked -> timeout after 16 BUSY cycles, then a clean fetch
        d_req = 1'b1; d_addr = 13'h055;
        gnt_q.push_back(1'b1);
        exp_q.push_back('{own: 1'b1, rdata: 8'h00, err: 1'b1});
        wait_gnt("t4");
        cyc = 0;
        while (mem_req && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        check("t4_mem_req_cycles", 32'(cyc), 32'd16);
        wait_done("t4");
        d_req = 1'b0;
        @(negedge clk);
        f_req = 1'b1; f_addr = 13'h100;
        gnt_q.push_back(1'b0);
        exp_q.push_back('{own: 1'b0, rdata: 8'h5A, err: 1'b0});
        wait_gnt("t4f");
        do_ack(1, 8'h5A);
        wait_done("t4f");
        f_req = 1'b0;
        @(negedge clk);

        // 5: reset during BUSY, pending fetch served afterwards
        d_req = 1'b1; d_we = 1'b0; d_addr = 13'h0CC;
        gnt_q.push_back(1'b1);
        wait_gnt("t5");
        f_req = 1'b1; f_addr = 13'h0DD;
        #2 rst = 1'b1;
        #1;
        check("t5_rst_mem_req", 32'(mem_req), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("t5_rst_no_done", 32'({f_done, d_done}), 32'd0);
        rst = 1'b0; d_req = 1'b0;
        gnt_q.push_back(1'b0);
        exp_q.push_back('{own: 1'b0, rdata: 8'hC3, err: 1'b0});
        wait_gnt("t5f");
        check("t5f_mem_addr", 32'(mem_addr), 32'h0DD);
        do_ack(0, 8'hC3);
        wait_done("t5f");
        f_req = 1'b0;
        @(negedge clk);

        // 6: stray ack in IDLE is ignored; ack on the timeout cycle completes normally
        mem_ack = 1'b1; mem_rdata = 8'hEE;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        check("t6_idle_busy", 32'(busy), 32'd0);
        check("t6_idle_pulses", 32'({f_gnt, d_gnt, f_done, d_done, mem_req}), 32'd0);
        @(negedge clk);
        check("t6_idle_done", 32'({f_done, d_done}), 32'd0);
        d_req = 1'b1; d_addr = 13'h0AB;
        gnt_q.push_back(1'b1);
        exp_q.push_back('{own: 1'b1, rdata: 8'h99, err: 1'b0});
        wait_gnt("t6");
        do_ack(15, 8'h99);
        wait_done("t6");
        d_req = 1'b0;
        @(negedge clk);
        check("t6_end_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
